// File: rtl/kasumi_csr_pkg.sv
// Shared constants, FSM state type and mstatus update helpers for the CSR/trap controller.
package kasumi_csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  // funct3 encodings of the Zicsr instructions
  localparam logic [2:0] OpRw  = 3'b001;
  localparam logic [2:0] OpRs  = 3'b010;
  localparam logic [2:0] OpRc  = 3'b011;
  localparam logic [2:0] OpRwi = 3'b101;
  localparam logic [2:0] OpRsi = 3'b110;
  localparam logic [2:0] OpRci = 3'b111;

  // mstatus bit positions
  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  typedef enum logic [3:0] {
    StIdle,
    StCsrWb,
    StTEpc,
    StTCause,
    StTTval,
    StTStat,
    StTRedir,
    StMStat,
    StMRedir
  } state_e;

  // Trap entry: stash MIE in MPIE, mask interrupts, record M as previous privilege
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MstatusMpie] = ms[MstatusMie];
    r[MstatusMie] = 1'b0;
    r[MstatusMppHi:MstatusMppLo] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE, re-arm MPIE, stay in M
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MstatusMie] = ms[MstatusMpie];
    r[MstatusMpie] = 1'b1;
    r[MstatusMppHi:MstatusMppLo] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR write-data and write-enable computation for the Zicsr ops.
module csr_alu
  import kasumi_csr_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs1_field,
  input  logic [31:0] rs1_data,
  input  logic [31:0] old,
  output logic [31:0] wdata,
  output logic        wen,
  output logic        op_ok
);

  logic [31:0] src;

  // Immediate forms take the rs1 field as a zero-extended uimm
  assign src = op[2] ? {27'b0, rs1_field} : rs1_data;

  // Set/clear with a zero source is a pure read and must not write
  always_comb begin
    wdata = src;
    wen   = 1'b0;
    op_ok = 1'b1;
    unique case (op)
      OpRw, OpRwi: begin
        wdata = src;
        wen   = 1'b1;
      end
      OpRs, OpRsi: begin
        wdata = old | src;
        wen   = (rs1_field != 5'd0);
      end
      OpRc, OpRci: begin
        wdata = old & ~src;
        wen   = (rs1_field != 5'd0);
      end
      default: op_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// CSR instruction, trap entry and MRET sequencer driving a single-port CSR file.
// Optional build macro CSR_TVAL_EN adds the mtval write step to trap entry.
module csr_trap_ctrl
  import kasumi_csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_field,
  input  logic [31:0] rs1_data,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [11:0] csr_raddr,
  output logic        wb_csr,
  output logic [11:0] write_addr,
  output logic [31:0] in_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        busy,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  state_e      state_q, state_d;
  logic [11:0] addr_q;
  logic [31:0] old_q, wdata_q, cause_q, pc_q;
  logic        wen_q, ill_q;
  logic        trap_take, csr_take;
  logic [31:0] alu_wdata;
  logic        alu_wen, alu_op_ok;

  csr_alu u_csr_alu (
    .op        (csr_op),
    .rs1_field (rs1_field),
    .rs1_data  (rs1_data),
    .old       (csr_rdata),
    .wdata     (alu_wdata),
    .wen       (alu_wen),
    .op_ok     (alu_op_ok)
  );

  // State register plus capture of the accepted instruction or trap operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      old_q   <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (csr_take) begin
        addr_q  <= csr_addr;
        old_q   <= csr_rdata;
        wdata_q <= alu_wdata;
        wen_q   <= alu_wen;
        // Read-only space is 11xx; only an actual write there is illegal
        ill_q   <= !alu_op_ok || (alu_wen && (csr_addr[11:10] == 2'b11));
      end
      if (trap_take) begin
        cause_q <= trap_cause;
        pc_q    <= trap_pc;
      end
    end
  end

`ifdef CSR_TVAL_EN
  logic [31:0] tval_q;

  // mtval operand captured alongside the rest of the trap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tval_q <= '0;
    end else if (trap_take) begin
      tval_q <= trap_tval;
    end
  end

  logic unused_bits;
  assign unused_bits = ^mtvec[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{trap_tval, mtvec[1:0]};
`endif

  assign busy = (state_q != StIdle);

  // Next-state decode and per-state CSR file / pipeline outputs
  always_comb begin
    state_d     = state_q;
    trap_take   = 1'b0;
    csr_take    = 1'b0;
    csr_raddr   = csr_addr;
    wb_csr      = 1'b0;
    write_addr  = '0;
    in_data     = '0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    illegal     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      StIdle: begin
        if (trap_req) begin
          trap_take = 1'b1;
          state_d   = StTEpc;
        end else if (mret_req) begin
          state_d = StMStat;
        end else if (inst_valid) begin
          csr_take = 1'b1;
          state_d  = StCsrWb;
        end
      end
      StCsrWb: begin
        state_d = StIdle;
        if (ill_q) begin
          illegal = 1'b1;
        end else begin
          rd_valid   = 1'b1;
          rd_data    = old_q;
          wb_csr     = wen_q;
          write_addr = addr_q;
          in_data    = wdata_q;
        end
      end
      StTEpc: begin
        wb_csr     = 1'b1;
        write_addr = CsrMepc;
        in_data    = pc_q;
        state_d    = StTCause;
      end
      StTCause: begin
        wb_csr     = 1'b1;
        write_addr = CsrMcause;
        in_data    = cause_q;
`ifdef CSR_TVAL_EN
        state_d    = StTTval;
`else
        state_d    = StTStat;
`endif
      end
`ifdef CSR_TVAL_EN
      StTTval: begin
        wb_csr     = 1'b1;
        write_addr = CsrMtval;
        in_data    = tval_q;
        state_d    = StTStat;
      end
`endif
      StTStat: begin
        csr_raddr  = CsrMstatus;
        wb_csr     = 1'b1;
        write_addr = CsrMstatus;
        in_data    = trap_mstatus(csr_rdata);
        state_d    = StTRedir;
      end
      StTRedir: begin
        // Direct mode only: low mode bits of mtvec are dropped
        redirect    = 1'b1;
        redirect_pc = {mtvec[31:2], 2'b00};
        state_d     = StIdle;
      end
      StMStat: begin
        csr_raddr  = CsrMstatus;
        wb_csr     = 1'b1;
        write_addr = CsrMstatus;
        in_data    = mret_mstatus(csr_rdata);
        state_d    = StMRedir;
      end
      StMRedir: begin
        redirect    = 1'b1;
        redirect_pc = mepc;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed cases plus randomized CSR ops,
// traps and MRETs against an arithmetic reference model. Honours CSR_TVAL_EN.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_field;
  logic [31:0] rs1_data;
  logic        trap_req;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        mret_req;
  logic [31:0] csr_rdata, mtvec, mepc;
  logic [11:0] csr_raddr;
  logic        wb_csr;
  logic [11:0] write_addr;
  logic [31:0] in_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        illegal;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  csr_trap_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .inst_valid  (inst_valid),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .rs1_field   (rs1_field),
    .rs1_data    (rs1_data),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret_req    (mret_req),
    .csr_rdata   (csr_rdata),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .csr_raddr   (csr_raddr),
    .wb_csr      (wb_csr),
    .write_addr  (write_addr),
    .in_data     (in_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .illegal     (illegal),
    .busy        (busy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: mstatus after trap entry / MRET, from the bit rules
  function automatic logic [31:0] ref_trap_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (((m >> 3) & 32'd1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ref_mret_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (((m >> 7) & 32'd1) << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  task automatic expect_write(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_wb"}, {31'b0, wb_csr}, 32'd1);
    chk({tag, "_addr"}, {20'b0, write_addr}, {20'b0, a});
    chk({tag, "_data"}, in_data, d);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    step();
  endtask

  task automatic do_csr(input string tag, input logic [2:0] op, input logic [11:0] a,
                        input logic [4:0] f, input logic [31:0] d, input logic [31:0] old);
    logic [31:0] src, exp_w;
    logic        writes, ill;
    src = op[2] ? {27'b0, f} : d;
    case (op[1:0])
      2'b01:   exp_w = src;
      2'b10:   exp_w = old | src;
      2'b11:   exp_w = old & ~src;
      default: exp_w = 32'd0;
    endcase
    writes = (op[1:0] == 2'b01) || (f != 5'd0);
    ill    = (op[1:0] == 2'b00) || (writes && (a[11:10] == 2'b11));
    inst_valid = 1'b1;
    csr_op = op;
    csr_addr = a;
    rs1_field = f;
    rs1_data = d;
    csr_rdata = old;
    #1;
    chk({tag, "_raddr"}, {20'b0, csr_raddr}, {20'b0, a});
    step();
    // Scramble sources to prove the values were registered at accept
    inst_valid = 1'b0;
    csr_rdata = $urandom;
    rs1_data = $urandom;
    #1;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    if (ill) begin
      chk({tag, "_ill"}, {31'b0, illegal}, 32'd1);
      chk({tag, "_wb"}, {31'b0, wb_csr}, 32'd0);
      chk({tag, "_rdv"}, {31'b0, rd_valid}, 32'd0);
    end else begin
      chk({tag, "_ill"}, {31'b0, illegal}, 32'd0);
      chk({tag, "_rdv"}, {31'b0, rd_valid}, 32'd1);
      chk({tag, "_rdd"}, rd_data, old);
      chk({tag, "_wb"}, {31'b0, wb_csr}, {31'b0, writes});
      if (writes) begin
        chk({tag, "_waddr"}, {20'b0, write_addr}, {20'b0, a});
        chk({tag, "_wdata"}, in_data, exp_w);
      end
    end
    step();
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_rdv0"}, {31'b0, rd_valid}, 32'd0);
  endtask

  task automatic do_trap(input string tag, input logic [31:0] c, input logic [31:0] p,
                         input logic [31:0] t, input logic [31:0] ms, input logic [31:0] tv,
                         input bit noise);
    trap_req = 1'b1;
    trap_cause = c;
    trap_pc = p;
    trap_tval = t;
    mtvec = tv;
    csr_rdata = ms;
    if (noise) begin
      mret_req = 1'b1;
      inst_valid = 1'b1;
      csr_op = 3'b001;
      csr_addr = 12'h340;
    end
    step();
    trap_req = 1'b0;
    trap_cause = $urandom;
    trap_pc = $urandom;
    trap_tval = $urandom;
    #1;
    expect_write({tag, "_epc"}, 12'h341, p);
    expect_write({tag, "_cause"}, 12'h342, c);
`ifdef CSR_TVAL_EN
    expect_write({tag, "_tval"}, 12'h343, t);
`endif
    chk({tag, "_stat_raddr"}, {20'b0, csr_raddr}, 32'h300);
    expect_write({tag, "_stat"}, 12'h300, ref_trap_ms(ms));
    mret_req = 1'b0;
    inst_valid = 1'b0;
    #1;
    chk({tag, "_redir"}, {31'b0, redirect}, 32'd1);
    chk({tag, "_rpc"}, redirect_pc, tv & ~32'd3);
    chk({tag, "_redir_wb"}, {31'b0, wb_csr}, 32'd0);
    step();
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_redir0"}, {31'b0, redirect}, 32'd0);
  endtask

  task automatic do_mret(input string tag, input logic [31:0] ms, input logic [31:0] ep);
    mret_req = 1'b1;
    csr_rdata = ms;
    mepc = ep;
    step();
    mret_req = 1'b0;
    #1;
    chk({tag, "_raddr"}, {20'b0, csr_raddr}, 32'h300);
    expect_write({tag, "_stat"}, 12'h300, ref_mret_ms(ms));
    chk({tag, "_redir"}, {31'b0, redirect}, 32'd1);
    chk({tag, "_rpc"}, redirect_pc, ep);
    step();
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inst_valid = 1'b0;
    csr_op = 3'b000;
    csr_addr = 12'h000;
    rs1_field = 5'd0;
    rs1_data = 32'd0;
    trap_req = 1'b0;
    trap_cause = 32'd0;
    trap_pc = 32'd0;
    trap_tval = 32'd0;
    mret_req = 1'b0;
    csr_rdata = 32'd0;
    mtvec = 32'd0;
    mepc = 32'd0;
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb", {31'b0, wb_csr}, 32'd0);
    chk("rst_rdv", {31'b0, rd_valid}, 32'd0);
    chk("rst_rdd", rd_data, 32'd0);
    chk("rst_ind", in_data, 32'd0);
    chk("rst_redir", {31'b0, redirect}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    reset = 1'b0;
    step();

    // Directed cases
    do_csr("csrrw_340", 3'b001, 12'h340, 5'd3, 32'hDEADBEEF, 32'h12);
    do_csr("csrrs_zero", 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h55);
    do_csr("csrrci", 3'b111, 12'h300, 5'd8, 32'h0, 32'h1888);
    do_csr("ro_write", 3'b001, 12'hC00, 5'd1, 32'h1, 32'h7);
    do_csr("ro_read", 3'b010, 12'hC00, 5'd0, 32'h1, 32'h9);
    do_csr("op100", 3'b100, 12'h340, 5'd1, 32'h1, 32'h7);
    do_trap("trap_dir", 32'd2, 32'h80, 32'h13, 32'h8, 32'h101, 1'b0);
    do_trap("trap_prio", 32'd11, 32'h400, 32'h77, 32'h0, 32'h2000, 1'b1);
    do_mret("mret_dir", 32'h80, 32'h200);

    // Reset landing in T_CAUSE must abort without further writes
    trap_req = 1'b1;
    trap_cause = 32'd5;
    trap_pc = 32'h900;
    mtvec = 32'h300;
    step();
    trap_req = 1'b0;
    expect_write("rst_mid_epc", 12'h341, 32'h900);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_wb", {31'b0, wb_csr}, 32'd0);
    chk("rst_mid_waddr", {20'b0, write_addr}, 32'd0);
    chk("rst_mid_ind", in_data, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_post_wb", {31'b0, wb_csr}, 32'd0);
      chk("rst_post_redir", {31'b0, redirect}, 32'd0);
      step();
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [11:0] a;
      logic [4:0]  f;
      a = 12'($urandom);
      if ($urandom_range(0, 3) == 0) a[11:10] = 2'b11;
      f = 5'($urandom);
      if ($urandom_range(0, 3) == 0) f = 5'd0;
      do_csr("rnd_csr", 3'($urandom), a, f, $urandom, $urandom);
      if (i % 5 == 0) do_trap("rnd_trap", $urandom, $urandom, $urandom, $urandom, $urandom,
                              bit'(i % 2));
      if (i % 5 == 2) do_mret("rnd_mret", $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
